// File: rtl/io_periph_unit.sv
// Memory-mapped I/O peripheral for the 16-bit RISC CPU: LED, GPIO, cycle timer
// with sticky compare flag, and a small scratch RAM behind a combinational read port.
module io_periph_unit #(
  parameter int unsigned SCRATCH_DEPTH = 16,
  parameter logic [15:0] SCRATCH_BASE  = 16'h0010
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic [15:0] addr,
  input  logic [15:0] data,
  input  logic        write,
  output logic [15:0] data_out,
  output logic [7:0]  led,
  output logic [15:0] gpio_out,
  input  logic [15:0] gpio_in,
  output logic        match_flag
);

  localparam int unsigned AW = (SCRATCH_DEPTH > 1) ? $clog2(SCRATCH_DEPTH) : 1;

  localparam logic [15:0] A_LED      = 16'h0000;
  localparam logic [15:0] A_GPIO_OUT = 16'h0001;
  localparam logic [15:0] A_GPIO_IN  = 16'h0002;
  localparam logic [15:0] A_CYCLE    = 16'h0003;
  localparam logic [15:0] A_CMP      = 16'h0004;
  localparam logic [15:0] A_STATUS   = 16'h0005;

  logic [15:0] gpio_s1;
  logic [15:0] gpio_s2;
  logic [15:0] cycle;
  logic [15:0] cmp;
  logic [15:0] scratch [SCRATCH_DEPTH];

  logic          in_scratch;
  logic [AW-1:0] scr_idx;
  logic          wr_led;
  logic          wr_gpio;
  logic          wr_cmp;
  logic          wr_clr;

  // Scratch window is aligned, so the upper bits select it and the lower bits index it.
  assign in_scratch = (addr[15:AW] == SCRATCH_BASE[15:AW]);
  assign scr_idx    = addr[AW-1:0];

  assign wr_led  = write && (addr == A_LED);
  assign wr_gpio = write && (addr == A_GPIO_OUT);
  assign wr_cmp  = write && (addr == A_CMP);
  assign wr_clr  = write && (addr == A_STATUS) && data[0];

  // Control/status registers, synchronizer and timer.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      led        <= 8'h00;
      gpio_out   <= 16'h0000;
      gpio_s1    <= 16'h0000;
      gpio_s2    <= 16'h0000;
      cycle      <= 16'h0000;
      cmp        <= 16'h0000;
      match_flag <= 1'b0;
    end else begin
      gpio_s1 <= gpio_in;
      gpio_s2 <= gpio_s1;
      cycle   <= cycle + 16'd1;
      if (wr_led)  led      <= data[7:0];
      if (wr_gpio) gpio_out <= data;
      if (wr_cmp)  cmp      <= data;
      // A match on the same edge as a clear keeps the flag set.
      if (cycle == cmp)  match_flag <= 1'b1;
      else if (wr_clr)   match_flag <= 1'b0;
    end
  end

  // Scratch RAM holds no reset value; a write during reset is dropped.
  always_ff @(posedge clk) begin
    if (!sync_rst && write && in_scratch) begin
      scratch[scr_idx] <= data;
    end
  end

  // Read decode over the full 16-bit address; unmapped locations read zero.
  always_comb begin
    data_out = 16'h0000;
    if (in_scratch) begin
      data_out = scratch[scr_idx];
    end else begin
      case (addr)
        A_LED:      data_out = {8'h00, led};
        A_GPIO_OUT: data_out = gpio_out;
        A_GPIO_IN:  data_out = gpio_s2;
        A_CYCLE:    data_out = cycle;
        A_CMP:      data_out = cmp;
        A_STATUS:   data_out = {15'h0000, match_flag};
        default:    data_out = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_io_periph_unit.sv
// Directed bench for io_periph_unit: write-side stimulus queues expected readbacks,
// which are drained and compared later; timer/flag checked against an edge-count model.
module tb_io_periph_unit;

  logic        clk = 1'b0;
  logic        sync_rst = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data = 16'h0000;
  logic        write = 1'b0;
  logic [15:0] data_out;
  logic [7:0]  led;
  logic [15:0] gpio_out;
  logic [15:0] gpio_in = 16'h0000;
  logic        match_flag;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [15:0] cyc_model = 16'h0000;
  logic [15:0] tgt;

  typedef struct {
    logic [15:0] a;
    logic [15:0] e;
    string       tag;
  } sb_t;
  sb_t sbq[$];

  io_periph_unit #(.SCRATCH_DEPTH(16), .SCRATCH_BASE(16'h0010)) dut (
    .clk(clk), .sync_rst(sync_rst), .addr(addr), .data(data), .write(write),
    .data_out(data_out), .led(led), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .match_flag(match_flag)
  );

  always #5 clk = ~clk;

  // Advance one edge; the bench counts edges to know what CYCLE should hold.
  task automatic tick();
    @(posedge clk);
    if (sync_rst) cyc_model = 16'h0000;
    else          cyc_model = cyc_model + 16'd1;
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
    addr  = a;
    write = 1'b0;
    #1;
    chk(tag, data_out, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr  = a;
    data  = d;
    write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic push(input string tag, input logic [15:0] a, input logic [15:0] e);
    sb_t s;
    s.a = a; s.e = e; s.tag = tag;
    sbq.push_back(s);
  endtask

  task automatic drain();
    sb_t s;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      rd(s.tag, s.a, s.e);
      tick();
    end
  endtask

  task automatic wait_cycle(input logic [15:0] target, input int unsigned budget);
    addr = 16'h0003;
    for (int unsigned i = 0; i < budget && cyc_model != target; i++) tick();
    rd("cycle_wait", 16'h0003, target);
  endtask

  initial begin
    // Reset state, read while reset is still held
    tick(); tick();
    rd("rst_led_rd", 16'h0000, 16'h0000);
    rd("rst_gpio_rd", 16'h0001, 16'h0000);
    rd("rst_cmp_rd", 16'h0004, 16'h0000);
    rd("rst_status_rd", 16'h0005, 16'h0000);
    rd("rst_cycle_rd", 16'h0003, 16'h0000);
    chk("rst_led", {8'h00, led}, 16'h0000);
    chk("rst_flag", {15'h0, match_flag}, 16'h0000);
    sync_rst = 1'b0;
    // First edge out of reset: CYCLE=1, and CYCLE(0)==CMP(0) sets the flag
    tick();
    rd("first_incr", 16'h0003, 16'h0001);
    chk("flag_at_cmp0", {15'h0, match_flag}, 16'h0001);

    // LED single write and held write
    wr(16'h0000, 16'hABCD);
    chk("led_wr", {8'h00, led}, 16'h00CD);
    rd("led_rd", 16'h0000, 16'h00CD);
    addr = 16'h0000; data = 16'hABCD; write = 1'b1;
    tick(); tick(); tick();
    write = 1'b0;
    chk("led_hold", {8'h00, led}, 16'h00CD);
    rd("led_hold_rd", 16'h0000, 16'h00CD);

    // GPIO out, synchronized GPIO in
    wr(16'h0001, 16'h1234);
    chk("gpio_out", gpio_out, 16'h1234);
    push("gpio_out_rd", 16'h0001, 16'h1234);
    addr = 16'h0002;
    gpio_in = 16'h5A5A;
    tick();
    rd("gpio_in_1clk", 16'h0002, 16'h0000);
    tick();
    rd("gpio_in_2clk", 16'h0002, 16'h5A5A);
    wr(16'h0002, 16'hFFFF);
    push("gpio_in_ro", 16'h0002, 16'h5A5A);

    // Scratch window edges, out-of-window and unmapped writes
    wr(16'h0010, 16'h1111);
    wr(16'h001F, 16'h2222);
    push("scr_first", 16'h0010, 16'h1111);
    push("scr_last", 16'h001F, 16'h2222);
    wr(16'h0020, 16'hBEEF);
    push("scr_past_end", 16'h0020, 16'h0000);
    push("scr_first_kept", 16'h0010, 16'h1111);
    push("scr_last_kept", 16'h001F, 16'h2222);
    wr(16'h0006, 16'hFFFF);
    push("unmapped_6", 16'h0006, 16'h0000);
    wr(16'h0100, 16'hFFFF);
    push("no_alias_100", 16'h0100, 16'h0000);
    push("led_no_alias", 16'h0000, 16'h00CD);
    drain();

    // Timer and compare flag from a fresh reset
    sync_rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    wr(16'h0004, 16'h0010);
    wr(16'h0005, 16'h0001);
    chk("flag_clear", {15'h0, match_flag}, 16'h0000);
    push("cmp_rd", 16'h0004, 16'h0010);
    drain();
    wait_cycle(16'h0010, 100);
    chk("flag_before_match", {15'h0, match_flag}, 16'h0000);
    tick();
    chk("flag_on_match", {15'h0, match_flag}, 16'h0001);
    rd("status_rd_set", 16'h0005, 16'h0001);
    wr(16'h0005, 16'h0000);
    chk("status_wr0_noeffect", {15'h0, match_flag}, 16'h0001);
    wr(16'h0005, 16'h0001);
    chk("flag_clear2", {15'h0, match_flag}, 16'h0000);
    wr(16'h0003, 16'h7777);
    rd("cycle_wr_ignored", 16'h0003, cyc_model);
    wait_cycle(16'hFFFF, 70000);
    tick();
    rd("cycle_wrap", 16'h0003, 16'h0000);
    wait_cycle(16'h0010, 100);
    chk("flag_pre_wrap_match", {15'h0, match_flag}, 16'h0000);
    tick();
    chk("flag_after_wrap", {15'h0, match_flag}, 16'h0001);

    // Clear issued on the exact match edge: set wins
    wr(16'h0005, 16'h0001);
    chk("flag_clear3", {15'h0, match_flag}, 16'h0000);
    tgt = cyc_model + 16'd6;
    wr(16'h0004, tgt);
    wait_cycle(tgt, 20);
    addr = 16'h0005; data = 16'h0001; write = 1'b1;
    tick();
    write = 1'b0;
    chk("set_beats_clear", {15'h0, match_flag}, 16'h0001);

    // Reset wins over a simultaneous LED write
    wr(16'h0000, 16'h0055);
    chk("led_pre_rst", {8'h00, led}, 16'h0055);
    sync_rst = 1'b1;
    addr = 16'h0000; data = 16'h00FF; write = 1'b1;
    tick();
    write = 1'b0;
    sync_rst = 1'b0;
    chk("rst_beats_write", {8'h00, led}, 16'h0000);
    chk("rst_gpio_out", gpio_out, 16'h0000);
    chk("rst_flag2", {15'h0, match_flag}, 16'h0000);
    rd("rst_cycle2", 16'h0003, 16'h0000);
    rd("rst_gpio_in", 16'h0002, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
